// File: rtl/key_input_ctrl.sv
// Debounced eight-key input peripheral with STATUS / EVENT / MASK registers and a level IRQ.
// Optional release-event latch at Addr 3 is enabled by defining KEY_RELEASE_EVT_EN.
module key_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  key_raw,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam int unsigned   NKEYS    = 8;
    localparam logic [7:0]    IDLE_LVL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       s1, s2, lv;
    logic [7:0]       stable, stable_nxt;
    logic [7:0]       evt_q, mask_q, rel_q, pending;
    logic [7:0]       press, wr_evt;
    logic [CNT_W-1:0] cnt     [NKEYS];
    logic [CNT_W-1:0] cnt_nxt [NKEYS];
    logic             unused_din;

    assign unused_din = ^Din[31:8];

    // Synchroniser resets to the idle pin level so no key looks pressed right after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= IDLE_LVL;
            s2 <= IDLE_LVL;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    assign lv = (ACTIVE_LOW != 0) ? ~s2 : s2;

    // Per-key debounce: any return to the accepted level restarts the count
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < NKEYS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (lv[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                stable_nxt[i] = lv[i];
                cnt_nxt[i]    = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
        end else begin
            stable <= stable_nxt;
            for (int i = 0; i < NKEYS; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    assign press  = stable_nxt & ~stable;
    assign wr_evt = (WE && (Addr == 2'd1)) ? Din[7:0] : 8'h00;

    // Event latch: a hardware set in the same cycle as a W1C wins
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q  <= '0;
            mask_q <= '0;
        end else begin
            evt_q <= (evt_q & ~wr_evt) | press;
            if (WE && (Addr == 2'd2)) mask_q <= Din[7:0];
        end
    end

`ifdef KEY_RELEASE_EVT_EN
    logic [7:0] fall, wr_rel;

    assign fall   = stable & ~stable_nxt;
    assign wr_rel = (WE && (Addr == 2'd3)) ? Din[7:0] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) rel_q <= '0;
        else       rel_q <= (rel_q & ~wr_rel) | fall;
    end

    assign pending = evt_q | rel_q;
`else
    assign rel_q   = 8'h00;
    assign pending = evt_q;
`endif

    always_comb begin
        Dout = '0;
        case (Addr)
            2'd0:    Dout = {24'b0, stable};
            2'd1:    Dout = {24'b0, evt_q};
            2'd2:    Dout = {24'b0, mask_q};
            default: Dout = {24'b0, rel_q};
        endcase
    end

    assign IRQ = |(pending & mask_q);

endmodule
